// File: rtl/if_prefetch_if.sv
// if_prefetch bus: IMEM fetch port, redirect input and IF/ID handshake.
// out_misalign exists only with MINA_PREFETCH_ALIGN_CHECK_EN.
interface if_prefetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_ia;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ia;
  logic [31:0] out_ia_plus_4;
  logic [31:0] out_ir;
`ifdef MINA_PREFETCH_ALIGN_CHECK_EN
  logic        out_misalign;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_ia,
    output out_valid,
    input  out_ready,
    output out_ia,
    output out_ia_plus_4,
    output out_ir,
    output out_misalign
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_ia,
    input  out_valid,
    output out_ready,
    input  out_ia,
    input  out_ia_plus_4,
    input  out_ir,
    input  out_misalign
  );
`else
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_ia,
    output out_valid,
    input  out_ready,
    output out_ia,
    output out_ia_plus_4,
    output out_ir
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_ia,
    input  out_valid,
    output out_ready,
    input  out_ia,
    input  out_ia_plus_4,
    input  out_ir
  );
`endif
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch queue between IMEM and IF/ID.
// Optional misaligned-redirect marker: MINA_PREFETCH_ALIGN_CHECK_EN.
module if_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] INITIAL_IA = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  if_prefetch_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] ia;
    logic [31:0] ir;
  } ent_t;

  ent_t          r_buf [DEPTH];
  logic [31:0]   r_fetch_ia;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_fetch_en;
  logic          w_mark;
  logic [31:0]   w_redir_ia;
  ent_t          w_head;
  ent_t          w_new;

`ifdef MINA_PREFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_FETCH,
    S_MARK,
    S_HALT
  } st_t;

  st_t  r_state;
  st_t  w_state_nxt;
  logic r_mis [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      bus.redirect_valid:
        w_state_nxt = (|bus.redirect_ia[1:0]) ? S_MARK : S_FETCH;
      (r_state == S_MARK) && w_push:
        w_state_nxt = S_HALT;
      default: ;
    endcase
  end

  always_comb begin
    w_fetch_en = (r_state == S_FETCH);
    w_mark     = (r_state == S_MARK);
  end

  assign w_redir_ia = bus.redirect_ia;

  always_ff @(posedge clk) begin
    if (w_push) r_mis[r_wr_ptr] <= w_mark;
  end

  assign bus.out_misalign = w_valid & r_mis[r_rd_ptr];
`else
  assign w_fetch_en = 1'b1;
  assign w_mark     = 1'b0;
  // Low address bits are dropped: redirects always fetch word-aligned.
  assign w_redir_ia = bus.redirect_ia & 32'hFFFF_FFFC;
`endif

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL);
  assign w_pop   = w_valid & bus.out_ready & ~bus.redirect_valid;
  assign w_push  = ~bus.redirect_valid & (w_fetch_en | w_mark)
                 & (~w_full | w_pop);

  assign w_new.ia = r_fetch_ia;
  assign w_new.ir = w_mark ? 32'h0 : bus.imem_data;

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_ia <= INITIAL_IA;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_ia <= w_redir_ia;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_fetch_en) r_fetch_ia <= r_fetch_ia + 32'd4;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign w_head = r_buf[r_rd_ptr];

  assign bus.imem_addr     = r_fetch_ia;
  assign bus.out_valid     = w_valid;
  assign bus.out_ia        = w_valid ? w_head.ia : 32'h0;
  assign bus.out_ia_plus_4 = w_valid ? w_head.ia + 32'd4 : 32'h0;
  assign bus.out_ir        = w_valid ? w_head.ir : 32'h0;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed-vector bench for if_prefetch.
// IMEM model returns address ^ 32'hA5A5_A5A5.
module tb_if_prefetch;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  if_prefetch_if bus ();

  if_prefetch #(
    .DEPTH      (4),
    .INITIAL_IA (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  assign bus.imem_data = bus.imem_addr ^ PAT;

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] ria;
    logic        rdy;
    logic        ev;
    logic [31:0] eia;
    logic [31:0] eaddr;
    logic        emis;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(logic r, logic rv, logic [31:0] ria,
                              logic rdy, logic ev, logic [31:0] eia,
                              logic [31:0] eaddr, logic emis);
    vec_t v;
    v.rst_n = r;
    v.rv    = rv;
    v.ria   = ria;
    v.rdy   = rdy;
    v.ev    = ev;
    v.eia   = eia;
    v.eaddr = eaddr;
    v.emis  = emis;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_row(int k, vec_t v);
    logic [31:0] eia;
    logic [31:0] eir;
    logic [31:0] ep4;
    eia = v.ev ? v.eia : 32'h0;
    ep4 = v.ev ? v.eia + 32'd4 : 32'h0;
    eir = (v.ev && !v.emis) ? (v.eia ^ PAT) : 32'h0;
    chk($sformatf("row%0d valid", k), {31'b0, bus.out_valid}, {31'b0, v.ev});
    chk($sformatf("row%0d addr", k), bus.imem_addr, v.eaddr);
    chk($sformatf("row%0d ia", k), bus.out_ia, eia);
    chk($sformatf("row%0d ir", k), bus.out_ir, eir);
    chk($sformatf("row%0d ia4", k), bus.out_ia_plus_4, ep4);
`ifdef MINA_PREFETCH_ALIGN_CHECK_EN
    chk($sformatf("row%0d mis", k), {31'b0, bus.out_misalign},
        {31'b0, v.emis});
`endif
  endtask

  initial begin
    int lat;

    // streaming after reset
    add(1, 0, 0, 1, 0, 32'h00, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h00, 32'h04, 0);
    add(1, 0, 0, 1, 1, 32'h04, 32'h08, 0);
    add(1, 0, 0, 1, 1, 32'h08, 32'h0C, 0);
    // stall fills, then drains
    add(1, 0, 0, 0, 1, 32'h0C, 32'h10, 0);
    add(1, 0, 0, 0, 1, 32'h0C, 32'h14, 0);
    add(1, 0, 0, 0, 1, 32'h0C, 32'h18, 0);
    add(1, 0, 0, 0, 1, 32'h0C, 32'h1C, 0);
    add(1, 0, 0, 0, 1, 32'h0C, 32'h1C, 0);
    add(1, 0, 0, 1, 1, 32'h0C, 32'h1C, 0);
    add(1, 0, 0, 1, 1, 32'h10, 32'h20, 0);
    add(1, 0, 0, 1, 1, 32'h14, 32'h24, 0);
    add(1, 0, 0, 1, 1, 32'h18, 32'h28, 0);
    add(1, 0, 0, 1, 1, 32'h1C, 32'h2C, 0);
    add(1, 0, 0, 1, 1, 32'h20, 32'h30, 0);
    // reset while full
    add(0, 0, 0, 0, 1, 32'h24, 32'h34, 0);
    // 10-cycle stall after reset
    add(1, 0, 0, 0, 0, 32'h00, 32'h00, 0);
    add(1, 0, 0, 0, 1, 32'h00, 32'h04, 0);
    add(1, 0, 0, 0, 1, 32'h00, 32'h08, 0);
    add(1, 0, 0, 0, 1, 32'h00, 32'h0C, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 1, 32'h00, 32'h10, 0);
    add(1, 0, 0, 1, 1, 32'h00, 32'h10, 0);
    add(1, 0, 0, 1, 1, 32'h04, 32'h14, 0);
    add(1, 0, 0, 1, 1, 32'h08, 32'h18, 0);
    add(1, 0, 0, 1, 1, 32'h0C, 32'h1C, 0);
    add(1, 0, 0, 1, 1, 32'h10, 32'h20, 0);
    add(1, 0, 0, 1, 1, 32'h14, 32'h24, 0);
    // redirect while full
    add(1, 0, 0, 0, 1, 32'h18, 32'h28, 0);
    add(1, 1, 32'h1000, 0, 1, 32'h18, 32'h28, 0);
    add(1, 0, 0, 0, 0, 32'h0, 32'h1000, 0);
    add(1, 0, 0, 1, 1, 32'h1000, 32'h1004, 0);
    add(1, 0, 0, 1, 1, 32'h1004, 32'h1008, 0);
    // redirect while streaming, address wrap
    add(1, 1, 32'hFFFF_FFF8, 1, 1, 32'h1008, 32'h100C, 0);
    add(1, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFF8, 0);
    add(1, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0);
    add(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0000_0000, 0);
    add(1, 0, 0, 1, 1, 32'h0000_0000, 32'h0000_0004, 0);
    // back-to-back redirects
    add(1, 1, 32'h2000, 1, 1, 32'h04, 32'h08, 0);
    add(1, 1, 32'h3000, 1, 0, 32'h0, 32'h2000, 0);
    add(1, 0, 0, 1, 0, 32'h0, 32'h3000, 0);
    add(1, 0, 0, 1, 1, 32'h3000, 32'h3004, 0);
    // reset holding 3 entries
    add(1, 0, 0, 0, 1, 32'h3004, 32'h3008, 0);
    add(1, 0, 0, 0, 1, 32'h3004, 32'h300C, 0);
    add(0, 0, 0, 0, 1, 32'h3004, 32'h3010, 0);
    add(1, 0, 0, 1, 0, 32'h0, 32'h0, 0);
    add(1, 0, 0, 1, 1, 32'h0, 32'h4, 0);
    // misaligned redirect
    add(1, 1, 32'h2002, 1, 1, 32'h4, 32'h8, 0);
`ifdef MINA_PREFETCH_ALIGN_CHECK_EN
    add(1, 0, 0, 1, 0, 32'h0, 32'h2002, 0);
    add(1, 0, 0, 1, 1, 32'h2002, 32'h2002, 1);
    add(1, 0, 0, 1, 0, 32'h0, 32'h2002, 0);
    add(1, 1, 32'h3000, 1, 0, 32'h0, 32'h2002, 0);
`else
    add(1, 0, 0, 1, 0, 32'h0, 32'h2000, 0);
    add(1, 0, 0, 1, 1, 32'h2000, 32'h2004, 0);
    add(1, 0, 0, 1, 1, 32'h2004, 32'h2008, 0);
    add(1, 1, 32'h3000, 1, 1, 32'h2008, 32'h200C, 0);
`endif
    add(1, 0, 0, 1, 0, 32'h0, 32'h3000, 0);
    add(1, 0, 0, 1, 1, 32'h3000, 32'h3004, 0);

    // reset state
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_ia    = 32'h0;
    bus.out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst addr", bus.imem_addr, 32'h0);
    chk("rst ia", bus.out_ia, 32'h0);
    chk("rst ir", bus.out_ir, 32'h0);
    chk("rst ia4", bus.out_ia_plus_4, 32'h0);

    foreach (tbl[k]) begin
      @(negedge clk);
      rst_n              = tbl[k].rst_n;
      bus.redirect_valid = tbl[k].rv;
      bus.redirect_ia    = tbl[k].ria;
      bus.out_ready      = tbl[k].rdy;
      #1;
      check_row(k, tbl[k]);
    end

    // redirect latency, bounded wait for out_valid
    @(negedge clk);
    rst_n              = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_ia    = 32'h0000_0040;
    lat = 99;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.redirect_ia    = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk("redir latency", 32'(lat), 32'd2);
    chk("redir ia", bus.out_ia, 32'h0000_0040);
    chk("redir ir", bus.out_ir, 32'h0000_0040 ^ PAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
